// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the E-stage forwarding/stall controller: operand source
// encodings, the default timing-field width and per-class Tnew/Tuse constants.
package hazard_fwd_ctrl_pkg;

    localparam int TW_DEF = 2;

    typedef enum logic [1:0] {
        SEL_GRF = 2'd0,
        SEL_M   = 2'd1,
        SEL_W   = 2'd2
    } sel_e;

    // Tnew counts from E entry; Tuse counts from D.
    localparam int TNEW_NONE = 0;
    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LOAD = 2;
    localparam int TUSE_BR   = 0;
    localparam int TUSE_ALU  = 1;

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline tracker stage: holds dest reg, remaining Tnew and write flag for the
// instruction in that stage. Optionally decrements Tnew (saturating) on entry.
module hazard_stage_reg #(
    parameter int TW     = 2,
    parameter bit DEC_IN = 1'b1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          bubble,
    input  logic [4:0]    in_wa,
    input  logic [TW-1:0] in_tnew,
    input  logic          in_rw,
    output logic [4:0]    wa,
    output logic [TW-1:0] tnew,
    output logic          rw
);

    logic [4:0]    wa_reg;
    logic [TW-1:0] tnew_reg;
    logic          rw_reg;
    logic [TW-1:0] tnew_next;

    always_comb begin
        tnew_next = in_tnew;
        if (DEC_IN && in_tnew != '0) begin
            tnew_next = in_tnew - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || bubble) begin
            wa_reg   <= '0;
            tnew_reg <= '0;
            rw_reg   <= 1'b0;
        end else begin
            wa_reg   <= in_wa;
            tnew_reg <= tnew_next;
            rw_reg   <= in_rw;
        end
    end

    assign wa   = wa_reg;
    assign tnew = tnew_reg;
    assign rw   = rw_reg;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard unit for a 5-stage pipeline: tracks producers in E/M/W, raises the D-stage
// stall and selects the forwarding source for each E operand.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    D_ReadA1,
    input  logic [4:0]    D_ReadA2,
    input  logic [TW-1:0] D_Tuse1,
    input  logic [TW-1:0] D_Tuse2,
    input  logic [4:0]    D_WriteA,
    input  logic [TW-1:0] D_Tnew,
    input  logic          D_RegWrite,
    output logic          Stall,
    output logic [1:0]    Trans_ALUIn_Sel1,
    output logic [1:0]    Trans_ALUIn_Sel2,
    output logic [4:0]    E_ReadA1,
    output logic [4:0]    E_ReadA2,
    output logic [31:0]   StallCnt
);

    localparam int ST_E = 0;
    localparam int ST_M = 1;
    localparam int ST_W = 2;

    logic [4:0]    st_in_wa   [3];
    logic [TW-1:0] st_in_tnew [3];
    logic          st_in_rw   [3];
    logic [4:0]    st_wa      [3];
    logic [TW-1:0] st_tnew    [3];
    logic          st_rw      [3];
    logic          st_prod    [3];

    logic          stall_next;
    logic [4:0]    e_a1_reg;
    logic [4:0]    e_a2_reg;
    logic [31:0]   stall_cnt_reg;
    sel_e          sel1_next;
    sel_e          sel2_next;

    // E is fed from D (no decrement, bubbled on stall); M and W age the previous stage.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stage
            if (gi == ST_E) begin : g_src_d
                assign st_in_wa[gi]   = D_WriteA;
                assign st_in_tnew[gi] = D_Tnew;
                assign st_in_rw[gi]   = D_RegWrite;
            end else begin : g_src_prev
                assign st_in_wa[gi]   = st_wa[gi-1];
                assign st_in_tnew[gi] = st_tnew[gi-1];
                assign st_in_rw[gi]   = st_rw[gi-1];
            end

            hazard_stage_reg #(
                .TW     (TW),
                .DEC_IN (gi != ST_E)
            ) u_stage (
                .clk     (clk),
                .srst    (reset),
                .bubble  ((gi == ST_E) ? stall_next : 1'b0),
                .in_wa   (st_in_wa[gi]),
                .in_tnew (st_in_tnew[gi]),
                .in_rw   (st_in_rw[gi]),
                .wa      (st_wa[gi]),
                .tnew    (st_tnew[gi]),
                .rw      (st_rw[gi])
            );

            // Register 0 is hardwired, so writing it never produces anything.
            assign st_prod[gi] = st_rw[gi] && (st_wa[gi] != 5'd0);
        end
    endgenerate

    always_comb begin
        stall_next =
            (st_prod[ST_E] && st_wa[ST_E] == D_ReadA1 && st_tnew[ST_E] > D_Tuse1) ||
            (st_prod[ST_M] && st_wa[ST_M] == D_ReadA1 && st_tnew[ST_M] > D_Tuse1) ||
            (st_prod[ST_E] && st_wa[ST_E] == D_ReadA2 && st_tnew[ST_E] > D_Tuse2) ||
            (st_prod[ST_M] && st_wa[ST_M] == D_ReadA2 && st_tnew[ST_M] > D_Tuse2);
    end

    always_ff @(posedge clk) begin
        if (reset || stall_next) begin
            e_a1_reg <= '0;
            e_a2_reg <= '0;
        end else begin
            e_a1_reg <= D_ReadA1;
            e_a2_reg <= D_ReadA2;
        end
    end

    // An M match still in flight (Tnew!=0) blocks W: W would hold a stale older value.
    function automatic sel_e pick_src(input logic [4:0] ra);
        sel_e s;
        s = SEL_GRF;
        if (ra != 5'd0) begin
            if (st_prod[ST_M] && st_wa[ST_M] == ra) begin
                s = (st_tnew[ST_M] == '0) ? SEL_M : SEL_GRF;
            end else if (st_prod[ST_W] && st_wa[ST_W] == ra) begin
                s = SEL_W;
            end
        end
        return s;
    endfunction

    always_comb begin
        sel1_next = pick_src(e_a1_reg);
        sel2_next = pick_src(e_a2_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (stall_next && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(sel1_next == SEL_M && st_tnew[ST_M] != '0));
            assert (!(sel2_next == SEL_M && st_tnew[ST_M] != '0));
        end
    end

    assign Stall            = stall_next;
    assign Trans_ALUIn_Sel1 = sel1_next;
    assign Trans_ALUIn_Sel2 = sel2_next;
    assign E_ReadA1         = e_a1_reg;
    assign E_ReadA2         = e_a2_reg;
    assign StallCnt         = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed instruction-sequence bench for hazard_fwd_ctrl with hand-computed
// stall, forwarding-select and stall-count expectations.
module tb_hazard_fwd_ctrl;
    import hazard_fwd_ctrl_pkg::*;

    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    D_ReadA1, D_ReadA2, D_WriteA;
    logic [TW-1:0] D_Tuse1, D_Tuse2, D_Tnew;
    logic          D_RegWrite;
    logic          Stall;
    logic [1:0]    Trans_ALUIn_Sel1, Trans_ALUIn_Sel2;
    logic [4:0]    E_ReadA1, E_ReadA2;
    logic [31:0]   StallCnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.TW(TW)) dut (
        .clk              (clk),
        .reset            (reset),
        .D_ReadA1         (D_ReadA1),
        .D_ReadA2         (D_ReadA2),
        .D_Tuse1          (D_Tuse1),
        .D_Tuse2          (D_Tuse2),
        .D_WriteA         (D_WriteA),
        .D_Tnew           (D_Tnew),
        .D_RegWrite       (D_RegWrite),
        .Stall            (Stall),
        .Trans_ALUIn_Sel1 (Trans_ALUIn_Sel1),
        .Trans_ALUIn_Sel2 (Trans_ALUIn_Sel2),
        .E_ReadA1         (E_ReadA1),
        .E_ReadA2         (E_ReadA2),
        .StallCnt         (StallCnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Present one instruction in D: rs, rt, Tuse1, Tuse2, dest, Tnew, RegWrite.
    task automatic set_d(input int a1, input int a2, input int tu1, input int tu2,
                         input int wa, input int tn, input int rw);
        D_ReadA1   = 5'(a1);
        D_ReadA2   = 5'(a2);
        D_Tuse1    = TW'(tu1);
        D_Tuse2    = TW'(tu2);
        D_WriteA   = 5'(wa);
        D_Tnew     = TW'(tn);
        D_RegWrite = rw[0];
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, TNEW_NONE, 0);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        nop();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("rst_stall", 32'(Stall), 0);
        check("rst_sel1", 32'(Trans_ALUIn_Sel1), 0);
        check("rst_sel2", 32'(Trans_ALUIn_Sel2), 0);
        check("rst_ea1", 32'(E_ReadA1), 0);
        check("rst_cnt", StallCnt, 0);

        // addu $1,$2,$3 ; addu $2,$1,$1
        set_d(2, 3, TUSE_ALU, TUSE_ALU, 1, TNEW_ALU, 1);
        #1 check("alu_a_stall", 32'(Stall), 0);
        tick();
        set_d(1, 1, TUSE_ALU, TUSE_ALU, 2, TNEW_ALU, 1);
        #1 check("alu_b_stall", 32'(Stall), 0);
        tick();
        nop();
        #1;
        check("alu_ea1", 32'(E_ReadA1), 1);
        check("alu_sel1_m", 32'(Trans_ALUIn_Sel1), SEL_M);
        check("alu_sel2_m", 32'(Trans_ALUIn_Sel2), SEL_M);
        flush();

        // lw $3,0($29) ; addu $4,$3,$0
        set_d(29, 0, TUSE_ALU, 3, 3, TNEW_LOAD, 1);
        #1 check("lw_stall0", 32'(Stall), 0);
        tick();
        set_d(3, 0, TUSE_ALU, TUSE_ALU, 4, TNEW_ALU, 1);
        #1 check("lwuse_stall", 32'(Stall), 1);
        tick();
        #1;
        check("lwuse_unstall", 32'(Stall), 0);
        check("lwuse_bubble_ea1", 32'(E_ReadA1), 0);
        check("lwuse_cnt", StallCnt, 1);
        tick();
        nop();
        #1;
        check("lwuse_ea1", 32'(E_ReadA1), 3);
        check("lwuse_sel1_w", 32'(Trans_ALUIn_Sel1), SEL_W);
        check("lwuse_sel2_grf", 32'(Trans_ALUIn_Sel2), SEL_GRF);
        flush();

        // lw $5 ; beq $5,$6
        set_d(29, 0, TUSE_ALU, 3, 5, TNEW_LOAD, 1);
        tick();
        set_d(5, 6, TUSE_BR, TUSE_BR, 0, TNEW_NONE, 0);
        #1 check("br_stall_e", 32'(Stall), 1);
        tick();
        #1 check("br_stall_m", 32'(Stall), 1);
        tick();
        #1;
        check("br_unstall", 32'(Stall), 0);
        check("br_cnt", StallCnt, 3);
        tick();
        nop();
        #1;
        check("br_ea1", 32'(E_ReadA1), 5);
        check("br_sel1_grf", 32'(Trans_ALUIn_Sel1), SEL_GRF);
        flush();

        // addu $1 ; addu $1 ; addu $7,$1,$9 -> M wins over W
        set_d(2, 3, TUSE_ALU, TUSE_ALU, 1, TNEW_ALU, 1);
        tick();
        set_d(4, 5, TUSE_ALU, TUSE_ALU, 1, TNEW_ALU, 1);
        tick();
        set_d(1, 9, TUSE_ALU, TUSE_ALU, 7, TNEW_ALU, 1);
        #1 check("mw_stall", 32'(Stall), 0);
        tick();
        nop();
        #1;
        check("mw_sel1_m", 32'(Trans_ALUIn_Sel1), SEL_M);
        check("mw_sel2_grf", 32'(Trans_ALUIn_Sel2), SEL_GRF);
        flush();

        // addu $0,$1,$2 ; beq $0,$0 -> $0 never stalls or forwards
        set_d(1, 2, TUSE_ALU, TUSE_ALU, 0, TNEW_ALU, 1);
        tick();
        set_d(0, 0, TUSE_BR, TUSE_BR, 0, TNEW_NONE, 0);
        #1 check("r0_stall", 32'(Stall), 0);
        tick();
        nop();
        #1;
        check("r0_sel1", 32'(Trans_ALUIn_Sel1), SEL_GRF);
        check("r0_sel2", 32'(Trans_ALUIn_Sel2), SEL_GRF);
        check("r0_cnt", StallCnt, 3);
        flush();

        // lw $3 in E with a stall pending, then reset
        set_d(29, 0, TUSE_ALU, 3, 3, TNEW_LOAD, 1);
        tick();
        set_d(3, 0, TUSE_ALU, TUSE_ALU, 4, TNEW_ALU, 1);
        #1 check("rstmid_stall_pre", 32'(Stall), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rstmid_stall", 32'(Stall), 0);
        check("rstmid_sel1", 32'(Trans_ALUIn_Sel1), SEL_GRF);
        check("rstmid_ea1", 32'(E_ReadA1), 0);
        check("rstmid_cnt", StallCnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
